// File: rtl/muldiv_if.sv
// Request/result bundle between the EX stage and muldiv_unit.
// The master side is the pipeline; the slave side is the unit.
interface muldiv_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      ALUOp;
    logic            regbit;
    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            md_sel;
    logic            busy;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport master (
        output in_valid, ALUOp, regbit, funct7, funct3, op_a, op_b, flush, out_ready,
        input  in_ready, md_sel, busy, out_valid, result
    );

    modport slave (
        input  in_valid, ALUOp, regbit, funct7, funct3, op_a, op_b, flush, out_ready,
        output in_ready, md_sel, busy, out_valid, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide.
// Define MULDIV_PAIRFUSE_EN to cache the last full product for MULH/MUL pairs.
module muldiv_unit #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave bus
);
    localparam int unsigned     Steps  = XLEN / BITS_PER_CYCLE;
    localparam int unsigned     CntW   = $clog2(Steps);
    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic            md_sel, accept, is_mul, is_rem, a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0] abs_a, abs_b, special_res;
    logic            div_zero, div_ovf, mul_zero, special, res_neg;

    assign md_sel  = (bus.ALUOp == 2'b00) && bus.regbit && (bus.funct7 == 7'b0000001);
    assign accept  = bus.in_valid && (state_q == StIdle) && md_sel && !bus.flush;
    assign is_mul  = !bus.funct3[2];
    assign is_rem  = bus.funct3[1];
    assign a_sgn   = is_mul ? (bus.funct3[1:0] != 2'b11) : !bus.funct3[0];
    assign b_sgn   = is_mul ? !bus.funct3[1] : !bus.funct3[0];
    assign a_neg   = a_sgn && bus.op_a[XLEN-1];
    assign b_neg   = b_sgn && bus.op_b[XLEN-1];
    assign abs_a   = a_neg ? -bus.op_a : bus.op_a;
    assign abs_b   = b_neg ? -bus.op_b : bus.op_b;
    // A remainder follows the dividend; products and quotients follow the sign xor.
    assign res_neg = (is_mul || !is_rem) ? (a_neg ^ b_neg) : a_neg;

    assign div_zero = !is_mul && (bus.op_b == '0);
    assign div_ovf  = !is_mul && !bus.funct3[0] && (bus.op_a == MinNeg) && (bus.op_b == '1);
    assign mul_zero = is_mul && ((bus.op_a == '0) || (bus.op_b == '0));
    assign special  = div_zero || div_ovf || mul_zero;

    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = is_rem ? bus.op_a : '1;
        end else if (div_ovf) begin
            special_res = is_rem ? '0 : bus.op_a;
        end
    end

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    logic [2*XLEN-1:0] step, prod;
    logic [XLEN:0]     sum, trial;
    logic [XLEN-1:0]   sel, fin_res;
    logic              last;

    always_comb begin
        step  = acc_q;
        sum   = '0;
        trial = '0;
        for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
            if (!funct3_q[2]) begin
                sum  = {1'b0, step[2*XLEN-1:XLEN]} + (step[0] ? {1'b0, opb_q} : '0);
                step = {sum, step[XLEN-1:1]};
            end else begin
                trial = step[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
                step  = trial[XLEN] ? {step[2*XLEN-2:0], 1'b0}
                                    : {trial[XLEN-1:0], step[XLEN-2:0], 1'b1};
            end
        end
    end

    always_comb begin
        prod    = neg_q ? -step : step;
        sel     = funct3_q[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
        fin_res = neg_q ? -sel : sel;
        if (!funct3_q[2]) begin
            fin_res = (funct3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
    end

    assign last = (cnt_q == CntW'(Steps - 1));

    logic            fuse_hit;
    logic [XLEN-1:0] fuse_res;

`ifdef MULDIV_PAIRFUSE_EN
    logic              cache_vld_q;
    logic [XLEN-1:0]   cache_a_q, cache_b_q, op_a_q, op_b_q;
    logic [1:0]        cache_cls_q, cls_q;
    logic [2*XLEN-1:0] cache_prod_q;

    assign fuse_hit = is_mul && cache_vld_q && (bus.op_a == cache_a_q) &&
                      (bus.op_b == cache_b_q) && ({a_sgn, b_sgn} == cache_cls_q);
    assign fuse_res = (bus.funct3[1:0] == 2'b00) ? cache_prod_q[XLEN-1:0]
                                                 : cache_prod_q[2*XLEN-1:XLEN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_vld_q  <= 1'b0;
            cache_a_q    <= '0;
            cache_b_q    <= '0;
            cache_cls_q  <= '0;
            cache_prod_q <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            cls_q        <= '0;
        end else begin
            if (accept) begin
                op_a_q <= bus.op_a;
                op_b_q <= bus.op_b;
                cls_q  <= {a_sgn, b_sgn};
            end
            if ((accept && !is_mul) || (bus.flush && (state_q != StIdle))) begin
                cache_vld_q <= 1'b0;
            end else if ((state_q == StCalc) && !bus.flush && last && !funct3_q[2]) begin
                cache_vld_q  <= 1'b1;
                cache_a_q    <= op_a_q;
                cache_b_q    <= op_b_q;
                cache_cls_q  <= cls_q;
                cache_prod_q <= prod;
            end
        end
    end
`else
    assign fuse_hit = 1'b0;
    assign fuse_res = '0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        funct3_d = funct3_q;
        neg_d    = neg_q;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    funct3_d = bus.funct3;
                    neg_d    = res_neg;
                    opb_d    = abs_b;
                    acc_d    = {{XLEN{1'b0}}, abs_a};
                    cnt_d    = '0;
                    if (special) begin
                        state_d  = StDone;
                        result_d = special_res;
                    end else if (fuse_hit) begin
                        state_d  = StDone;
                        result_d = fuse_res;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                if (bus.flush) begin
                    state_d = StIdle;
                end else begin
                    acc_d = step;
                    cnt_d = cnt_q + CntW'(1);
                    if (last) begin
                        state_d  = StDone;
                        result_d = fin_res;
                    end
                end
            end
            StDone: begin
                if (bus.flush || bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            funct3_q <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            funct3_q <= funct3_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign bus.md_sel    = md_sel;
    assign bus.in_ready  = (state_q == StIdle);
    assign bus.busy      = (state_q != StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.result    = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus handshake, flush and reset sequences.
module tb_muldiv_unit;
    localparam int XLEN = 32;
`ifdef MULDIV_PAIRFUSE_EN
    localparam int FuseLat = 1;
`else
    localparam int FuseLat = 33;
`endif
    localparam logic [2:0] FMul = 3'd0, FMulh = 3'd1, FMulhsu = 3'd2, FMulhu = 3'd3;
    localparam logic [2:0] FDiv = 3'd4, FDivu = 3'd5, FRem = 3'd6, FRemu = 3'd7;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    muldiv_if #(.XLEN(XLEN)) bus ();
    muldiv_unit #(.XLEN(XLEN), .BITS_PER_CYCLE(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input string n, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] e, input int l);
        vec_t v;
        v.name = n; v.f3 = f3; v.a = a; v.b = b; v.exp = e; v.lat = l;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bus.ALUOp  = 2'b00;
        bus.regbit = 1'b1;
        bus.funct7 = 7'b0000001;
        bus.funct3 = f3;
        bus.op_a   = a;
        bus.op_b   = b;
    endtask

    // Cycles counted from raising in_valid to seeing out_valid; then the result handshake.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output logic held);
        set_op(f3, a, b);
        bus.in_valid = 1'b1;
        lat  = 0;
        held = 1'b1;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            bus.in_valid = 1'b0;
            if (!bus.busy || bus.in_ready) held = 1'b0;
            if (bus.out_valid) break;
        end
        res = bus.result;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic start(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        set_op(f3, a, b);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!bus.out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] res;
        int          lat;
        logic        held;
        logic        bad;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        set_op(FMul, 32'd0, 32'd0);
        bus.funct7    = 7'd0;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result", bus.result, 32'd0);
        #21 rst_n = 1'b1;
        @(posedge clk); #1;

        // md_sel decode and ignored non-M requests
        set_op(FMul, 32'd3, 32'd4);
        #1 check("md_sel_on", 32'(bus.md_sel), 32'd1);
        bus.funct7 = 7'b0000000;
        #1 check("md_sel_f7", 32'(bus.md_sel), 32'd0);
        bus.funct7 = 7'b0000001; bus.ALUOp = 2'b10;
        #1 check("md_sel_aluop", 32'(bus.md_sel), 32'd0);
        bus.ALUOp = 2'b00; bus.regbit = 1'b0;
        #1 check("md_sel_regbit", 32'(bus.md_sel), 32'd0);
        bus.in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.in_valid = 1'b0;
        check("ignored_busy", 32'(bus.busy), 32'd0);
        check("ignored_in_ready", 32'(bus.in_ready), 32'd1);

        vq.push_back(mk("mul_7x-3",       FMul,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33));
        vq.push_back(mk("mulh_min2",      FMulh,   32'h80000000, 32'h80000000, 32'h40000000, 33));
        vq.push_back(mk("mulhu_ones",     FMulhu,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33));
        vq.push_back(mk("mulhsu_ones",    FMulhsu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33));
        vq.push_back(mk("div_-7/2",       FDiv,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33));
        vq.push_back(mk("rem_-7/2",       FRem,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33));
        vq.push_back(mk("divu_100/0",     FDivu,   32'd100,      32'd0,        32'hFFFFFFFF, 1));
        vq.push_back(mk("rem_ovf",        FRem,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1));
        vq.push_back(mk("div_ovf",        FDiv,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1));
        vq.push_back(mk("remu_100/0",     FRemu,   32'd100,      32'd0,        32'd100,      1));
        vq.push_back(mk("mul_0x5",        FMul,    32'd0,        32'd5,        32'd0,        1));
        vq.push_back(mk("divu_100/7",     FDivu,   32'd100,      32'd7,        32'd14,       33));
        vq.push_back(mk("remu_100/7",     FRemu,   32'd100,      32'd7,        32'd2,        33));
        vq.push_back(mk("mul_shift",      FMul,    32'h12345678, 32'h10,       32'h23456780, 33));
        vq.push_back(mk("mulhu_shift",    FMulhu,  32'h12345678, 32'h10,       32'h1,        33));
        vq.push_back(mk("div_7/-2",       FDiv,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33));
        vq.push_back(mk("rem_7/-2",       FRem,    32'd7,        32'hFFFFFFFE, 32'd1,        33));
        vq.push_back(mk("div_0/5",        FDiv,    32'd0,        32'd5,        32'd0,        33));

        foreach (vq[i]) begin
            do_op(vq[i].f3, vq[i].a, vq[i].b, res, lat, held);
            check({vq[i].name, "_res"}, res, vq[i].exp);
            check({vq[i].name, "_lat"}, 32'(lat), 32'(vq[i].lat));
            check({vq[i].name, "_busy"}, 32'(held), 32'd1);
        end

        // Result held while out_ready is low; a pending request must not sneak in.
        start(FMul, 32'd7, 32'hFFFFFFFD);
        wait_valid(lat);
        check("stall_lat", 32'(lat), 32'd32);
        set_op(FDivu, 32'd100, 32'd0);
        bus.in_valid = 1'b1;
        bad = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (!bus.out_valid || bus.result !== 32'hFFFFFFEB || bus.in_ready) bad = 1'b1;
        end
        check("stall_stable", 32'(bad), 32'd0);
        bus.out_ready = 1'b1;
        #1 check("stall_ready_blocked", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check("stall_done_valid", 32'(bus.out_valid), 32'd0);
        check("stall_done_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        check("stall_no_accept", 32'(bus.busy), 32'd0);

        // Flush in the tenth CALC cycle
        start(FDivu, 32'd100, 32'd7);
        repeat (9) begin
            @(posedge clk); #1;
        end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush_in_ready", 32'(bus.in_ready), 32'd1);
        check("flush_busy", 32'(bus.busy), 32'd0);
        bad = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid) bad = 1'b1;
        end
        check("flush_no_valid", 32'(bad), 32'd0);
        do_op(FRemu, 32'd100, 32'd7, res, lat, held);
        check("after_flush_res", res, 32'd2);
        check("after_flush_lat", 32'(lat), 32'd33);

        // Flush beats out_ready in DONE
        start(FDivu, 32'd100, 32'd0);
        check("flush_done_valid", 32'(bus.out_valid), 32'd1);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        check("flush_done_drop", 32'(bus.out_valid), 32'd0);
        check("flush_done_idle", 32'(bus.in_ready), 32'd1);

        // Asynchronous reset mid-CALC, away from any clock edge
        start(FMul, 32'd7, 32'hFFFFFFFD);
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        check("pre_rst_result", bus.result, 32'hFFFFFFFF);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_result", bus.result, 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // MULH/MUL pair on the same operands, then a divide in between
        do_op(FMulh, 32'd7, 32'hFFFFFFFD, res, lat, held);
        check("pair_mulh_res", res, 32'hFFFFFFFF);
        check("pair_mulh_lat", 32'(lat), 32'd33);
        do_op(FMul, 32'd7, 32'hFFFFFFFD, res, lat, held);
        check("pair_mul_res", res, 32'hFFFFFFEB);
        check("pair_mul_lat", 32'(lat), 32'(FuseLat));
        do_op(FDivu, 32'd100, 32'd7, res, lat, held);
        check("pair_divu_res", res, 32'd14);
        do_op(FMul, 32'd7, 32'hFFFFFFFD, res, lat, held);
        check("pair_inval_res", res, 32'hFFFFFFEB);
        check("pair_inval_lat", 32'(lat), 32'd33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
